ifm_window_addr_gen: RTL and testbench

IFM_WINDOW_ADDR_GEN -- requirements
Module: ifm_window_addr_gen

---
 rtl/ifm_window_addr_gen.sv | 207 ++++++++++++++++++++
 tb/tb_ifm_window_addr_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_window_addr_gen.sv
// Convolution window address generator: walks a tile's output windows in raster order, LANES per beat.
// Optional cfg_err output is built when IFM_WINDOW_ADDR_GEN_CFG_CHK_EN is defined.
module ifm_window_addr_gen #(
  parameter int LANES  = 8,
  parameter int ADDR_W = 10,
  parameter int DIM_W  = 6
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      tile_start,
  input  logic [DIM_W-1:0]          tile_length,
  input  logic [DIM_W-1:0]          tile_height,
  input  logic [2:0]                stride,
  input  logic [2:0]                ksize,
  input  logic [ADDR_W-1:0]         tile_base,
  output logic [LANES*ADDR_W-1:0]   base_address,
  output logic [LANES-1:0]          lane_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
`ifdef IFM_WINDOW_ADDR_GEN_CFG_CHK_EN
  output logic                      cfg_err,
`endif
  output logic                      tile_done
);

  localparam int COL_W  = DIM_W + 1;
  localparam int TOT_W  = 2 * COL_W;
  localparam int PROD_W = DIM_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

  state_t                     r_state;
  logic [DIM_W-1:0]           r_len;
  logic [DIM_W-1:0]           r_hgt;
  logic [2:0]                 r_stride;
  logic [2:0]                 r_ksize;
  logic [ADDR_W-1:0]          r_base;
  logic [ADDR_W-1:0]          r_nx_addr;
  logic [ADDR_W-1:0]          r_nx_rowb;
  logic [COL_W-1:0]           r_nx_col;
  logic [TOT_W-1:0]           r_nx_rem;
  logic [LANES*ADDR_W-1:0]    r_base_address;
  logic [LANES-1:0]           r_lane_valid;
  logic                       r_out_valid;
  logic                       r_out_last;
  logic                       r_busy;
  logic                       r_tile_done;

  logic [COL_W-1:0]           w_len_x;
  logic [COL_W-1:0]           w_hgt_x;
  logic [COL_W-1:0]           w_k_x;
  logic [COL_W-1:0]           w_s_x;
  logic [COL_W-1:0]           w_out_w;
  logic [COL_W-1:0]           w_out_h;
  logic [TOT_W-1:0]           w_total;
  logic [PROD_W-1:0]          w_prod;
  logic [ADDR_W-1:0]          w_row_step;
  logic [ADDR_W-1:0]          w_stride_a;
  logic                       w_in_setup;
  logic [ADDR_W-1:0]          w_seed_addr;
  logic [ADDR_W-1:0]          w_seed_rowb;
  logic [COL_W-1:0]           w_seed_col;
  logic [TOT_W-1:0]           w_seed_rem;
  logic [LANES*ADDR_W-1:0]    w_beat_addr;
  logic [LANES-1:0]           w_beat_vld;
  logic                       w_beat_last;
  logic [ADDR_W-1:0]          w_end_addr;
  logic [ADDR_W-1:0]          w_end_rowb;
  logic [COL_W-1:0]           w_end_col;
  logic                       w_load;

  // Output geometry comes from the latched configuration, which is frozen outside IDLE.
  assign w_len_x    = COL_W'(r_len);
  assign w_hgt_x    = COL_W'(r_hgt);
  assign w_k_x      = COL_W'(r_ksize);
  assign w_s_x      = COL_W'(r_stride);
  assign w_out_w    = (r_stride == 3'd0 || w_len_x < w_k_x) ? '0 : (w_len_x - w_k_x) / w_s_x + COL_W'(1);
  assign w_out_h    = (r_stride == 3'd0 || w_hgt_x < w_k_x) ? '0 : (w_hgt_x - w_k_x) / w_s_x + COL_W'(1);
  assign w_total    = TOT_W'(w_out_w) * TOT_W'(w_out_h);
  assign w_prod     = PROD_W'(r_len) * PROD_W'(r_stride);
  assign w_row_step = ADDR_W'(w_prod);
  assign w_stride_a = ADDR_W'(r_stride);

  // The first beat is seeded from the tile origin; later beats continue from the saved walker.
  assign w_in_setup  = (r_state == S_SETUP);
  assign w_seed_addr = w_in_setup ? r_base  : r_nx_addr;
  assign w_seed_rowb = w_in_setup ? r_base  : r_nx_rowb;
  assign w_seed_col  = w_in_setup ? '0      : r_nx_col;
  assign w_seed_rem  = w_in_setup ? w_total : r_nx_rem;
  assign w_beat_last = (w_seed_rem <= TOT_W'(LANES));

  always_comb begin
    logic [ADDR_W-1:0] v_addr;
    logic [ADDR_W-1:0] v_rowb;
    logic [COL_W-1:0]  v_col;
    v_addr      = w_seed_addr;
    v_rowb      = w_seed_rowb;
    v_col       = w_seed_col;
    w_beat_addr = '0;
    w_beat_vld  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_seed_rem > TOT_W'(i)) begin
        w_beat_vld[i]                  = 1'b1;
        w_beat_addr[i*ADDR_W +: ADDR_W] = v_addr;
      end
      if (v_col + COL_W'(1) == w_out_w) begin
        v_col  = '0;
        v_rowb = v_rowb + w_row_step;
        v_addr = v_rowb;
      end else begin
        v_col  = v_col + COL_W'(1);
        v_addr = v_addr + w_stride_a;
      end
    end
    w_end_addr = v_addr;
    w_end_rowb = v_rowb;
    w_end_col  = v_col;
  end

  assign w_load = (w_in_setup && w_total != '0) ||
                  (r_state == S_RUN && r_out_valid && out_ready && !r_out_last);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_hgt          <= '0;
      r_stride       <= '0;
      r_ksize        <= '0;
      r_base         <= '0;
      r_nx_addr      <= '0;
      r_nx_rowb      <= '0;
      r_nx_col       <= '0;
      r_nx_rem       <= '0;
      r_base_address <= '0;
      r_lane_valid   <= '0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_busy         <= 1'b0;
      r_tile_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tile_done <= 1'b0;
          if (tile_start) begin
            r_len    <= tile_length;
            r_hgt    <= tile_height;
            r_stride <= stride;
            r_ksize  <= ksize;
            r_base   <= tile_base;
            r_busy   <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_total == '0) begin
            r_tile_done <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_out_valid && out_ready && r_out_last) begin
            r_base_address <= '0;
            r_lane_valid   <= '0;
            r_out_valid    <= 1'b0;
            r_out_last     <= 1'b0;
            r_tile_done    <= 1'b1;
            r_state        <= S_DONE;
          end
        end
        default: begin
          r_tile_done <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
      // A beat is only replaced on acceptance, so a stalled beat holds its value.
      if (w_load) begin
        r_base_address <= w_beat_addr;
        r_lane_valid   <= w_beat_vld;
        r_out_last     <= w_beat_last;
        r_out_valid    <= 1'b1;
        r_nx_addr      <= w_end_addr;
        r_nx_rowb      <= w_end_rowb;
        r_nx_col       <= w_end_col;
        r_nx_rem       <= w_seed_rem - TOT_W'(LANES);
      end
    end
  end

  assign base_address = r_base_address;
  assign lane_valid   = r_lane_valid;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign busy         = r_busy;
  assign tile_done    = r_tile_done;

`ifdef IFM_WINDOW_ADDR_GEN_CFG_CHK_EN
  assign cfg_err = w_in_setup &&
                   (r_stride == 3'd0 || r_ksize == 3'd0 || w_k_x > w_len_x || w_k_x > w_hgt_x);
`endif

endmodule

// File: tb/tb_ifm_window_addr_gen.sv
// Directed bench for ifm_window_addr_gen: table of tiles with hand-computed beats plus stall/reset/empty sequences.
module tb_ifm_window_addr_gen;

  logic        clock = 1'b0;
  logic        rst;
  logic        tile_start;
  logic [5:0]  tile_length;
  logic [5:0]  tile_height;
  logic [2:0]  stride;
  logic [2:0]  ksize;
  logic [9:0]  tile_base;
  logic [79:0] base_address;
  logic [7:0]  lane_valid;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        tile_done;
`ifdef IFM_WINDOW_ADDR_GEN_CFG_CHK_EN
  logic        cfg_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ifm_window_addr_gen #(.LANES(8), .ADDR_W(10), .DIM_W(6)) dut (
    .clock(clock),
    .rst(rst),
    .tile_start(tile_start),
    .tile_length(tile_length),
    .tile_height(tile_height),
    .stride(stride),
    .ksize(ksize),
    .tile_base(tile_base),
    .base_address(base_address),
    .lane_valid(lane_valid),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
`ifdef IFM_WINDOW_ADDR_GEN_CFG_CHK_EN
    .cfg_err(cfg_err),
`endif
    .tile_done(tile_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0]       len;
    logic [5:0]       hgt;
    logic [2:0]       k;
    logic [2:0]       s;
    logic [9:0]       base;
    logic [1:0]       nbeats;
    logic [1:0][79:0] addr;
    logic [1:0][7:0]  vld;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [79:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    logic [79:0] v;
    v = {10'(a7), 10'(a6), 10'(a5), 10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    return v;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 80'(out_valid), 80'd0);
    chk({tag, "_last"},  80'(out_last),  80'd0);
    chk({tag, "_addr"},  base_address,   80'd0);
    chk({tag, "_vld"},   80'(lane_valid), 80'd0);
  endtask

  task automatic drive_cfg(input int idx);
    tile_length = tbl[idx].len;
    tile_height = tbl[idx].hgt;
    ksize       = tbl[idx].k;
    stride      = tbl[idx].s;
    tile_base   = tbl[idx].base;
  endtask

  task automatic scramble_cfg();
    tile_length = 6'h3f;
    tile_height = 6'h01;
    ksize       = 3'd0;
    stride      = 3'd7;
    tile_base   = 10'h155;
  endtask

  task automatic check_beat(input int idx, input int b, input string tag);
    $display("[TB] tile %0d beat %0d %s: addr=%h vld=%h last=%b", idx, b, tag, base_address, lane_valid, out_last);
    chk({tag, "_valid"}, 80'(out_valid), 80'd1);
    chk({tag, "_addr"},  base_address, tbl[idx].addr[b]);
    chk({tag, "_vld"},   80'(lane_valid), 80'(tbl[idx].vld[b]));
    chk({tag, "_last"},  80'(out_last), (b == int'(tbl[idx].nbeats) - 1) ? 80'd1 : 80'd0);
  endtask

  // Full tile with ready held high: SETUP, back-to-back beats, DONE pulse, IDLE.
  task automatic run_tile(input int idx);
    out_ready = 1'b1;
    @(negedge clock);
    drive_cfg(idx);
    tile_start = 1'b1;
    @(negedge clock);
    tile_start = 1'b0;
    scramble_cfg();
    chk("setup_valid", 80'(out_valid), 80'd0);
    chk("setup_busy",  80'(busy), 80'd1);
    for (int b = 0; b < int'(tbl[idx].nbeats); b++) begin
      @(negedge clock);
      check_beat(idx, b, "beat");
    end
    @(negedge clock);
    chk("done_pulse", 80'(tile_done), 80'd1);
    chk("done_valid", 80'(out_valid), 80'd0);
    @(negedge clock);
    chk("done_clear", 80'(tile_done), 80'd0);
    chk("idle_busy",  80'(busy), 80'd0);
  endtask

  initial begin
    // L=6 H=5 K=3 S=1: 4x3 windows, partial second beat.
    tbl[0] = '{len:6'd6, hgt:6'd5, k:3'd3, s:3'd1, base:10'd0, nbeats:2'd2,
               addr:{pk(12,13,14,15,0,0,0,0), pk(0,1,2,3,6,7,8,9)}, vld:{8'h0F, 8'hFF}};
    tbl[1] = '{len:6'd8, hgt:6'd8, k:3'd2, s:3'd2, base:10'd100, nbeats:2'd2,
               addr:{pk(132,134,136,138,148,150,152,154), pk(100,102,104,106,116,118,120,122)},
               vld:{8'hFF, 8'hFF}};
    tbl[2] = '{len:6'd4, hgt:6'd4, k:3'd1, s:3'd1, base:10'd1020, nbeats:2'd2,
               addr:{pk(4,5,6,7,8,9,10,11), pk(1020,1021,1022,1023,0,1,2,3)}, vld:{8'hFF, 8'hFF}};
    tbl[3] = '{len:6'd6, hgt:6'd6, k:3'd3, s:3'd1, base:10'd0, nbeats:2'd2,
               addr:{pk(12,13,14,15,18,19,20,21), pk(0,1,2,3,6,7,8,9)}, vld:{8'hFF, 8'hFF}};
    tbl[4] = '{len:6'd5, hgt:6'd3, k:3'd3, s:3'd2, base:10'd7, nbeats:2'd1,
               addr:{80'd0, pk(7,9,0,0,0,0,0,0)}, vld:{8'h00, 8'h03}};
    // One window per row: every lane is a row wrap.
    tbl[5] = '{len:6'd3, hgt:6'd7, k:3'd3, s:3'd1, base:10'd2, nbeats:2'd1,
               addr:{80'd0, pk(2,5,8,11,14,0,0,0)}, vld:{8'h00, 8'h1F}};

    rst        = 1'b1;
    tile_start = 1'b0;
    out_ready  = 1'b1;
    scramble_cfg();
    @(negedge clock);
    chk_idle_outputs("reset");
    chk("reset_busy", 80'(busy), 80'd0);
    chk("reset_done", 80'(tile_done), 80'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_tile(i);

    // Stall for 5 cycles on beat 0, with an ignored tile_start during the stall.
    out_ready = 1'b0;
    @(negedge clock);
    drive_cfg(1);
    tile_start = 1'b1;
    @(negedge clock);
    tile_start = 1'b0;
    scramble_cfg();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_beat(1, 0, "stall");
      if (i == 0) begin
        drive_cfg(0);
        tile_start = 1'b1;
      end else begin
        tile_start = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(negedge clock);
    check_beat(1, 1, "after_stall");
    out_ready = 1'b0;
    @(negedge clock);
    check_beat(1, 1, "stall_last");
    out_ready = 1'b1;
    @(negedge clock);
    chk("stall_done", 80'(tile_done), 80'd1);
    @(negedge clock);
    chk("stall_idle", 80'(busy), 80'd0);
    @(negedge clock);
    chk("no_queue_busy",  80'(busy), 80'd0);
    chk("no_queue_valid", 80'(out_valid), 80'd0);

    // Empty tile: K larger than the tile, straight from SETUP to DONE.
    @(negedge clock);
    tile_length = 6'd4;
    tile_height = 6'd4;
    ksize       = 3'd5;
    stride      = 3'd1;
    tile_base   = 10'd0;
    tile_start  = 1'b1;
    @(negedge clock);
    tile_start = 1'b0;
    chk("empty_setup_valid", 80'(out_valid), 80'd0);
    chk("empty_setup_busy",  80'(busy), 80'd1);
    chk("empty_setup_done",  80'(tile_done), 80'd0);
`ifdef IFM_WINDOW_ADDR_GEN_CFG_CHK_EN
    chk("empty_cfg_err", 80'(cfg_err), 80'd1);
`endif
    @(negedge clock);
    chk("empty_done",  80'(tile_done), 80'd1);
    chk("empty_valid", 80'(out_valid), 80'd0);
`ifdef IFM_WINDOW_ADDR_GEN_CFG_CHK_EN
    chk("empty_cfg_err_clear", 80'(cfg_err), 80'd0);
`endif
    @(negedge clock);
    chk("empty_idle", 80'(busy), 80'd0);

    // Asynchronous reset in the middle of a tile.
    @(negedge clock);
    drive_cfg(0);
    tile_start = 1'b1;
    @(negedge clock);
    tile_start = 1'b0;
    @(negedge clock);
    check_beat(0, 0, "pre_reset");
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_reset");
    chk("async_reset_busy", 80'(busy), 80'd0);
    chk("async_reset_done", 80'(tile_done), 80'd0);
    @(negedge clock);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("post_reset_done", 80'(tile_done), 80'd0);
      chk("post_reset_busy", 80'(busy), 80'd0);
    end
    run_tile(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
